ifetch_queue: RTL and testbench

//  Instruction fetch front end that sits between the PC/instruction-memory side and the single-cycle core's decode.

---
 rtl/ifetch_pkg.sv | 12 +
 rtl/ifetch_queue_fetch_fifo.sv | 60 ++++++
 rtl/ifetch_queue.sv | 107 ++++++++++
 tb/tb_ifetch_queue.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package ifetch_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h00000013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h00400000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_queue_fetch_fifo.sv
// In-order buffer of fetched words. Pointers carry an extra wrap bit so that
// full and empty are told apart without a separate counter.
module fetch_fifo
    import ifetch_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_flush,
    input  logic         i_push,
    input  fetch_entry_t i_data,
    input  logic         i_pop,
    output fetch_entry_t o_head,
    output logic         o_empty,
    output logic [AW:0]  o_count
);

    localparam logic [AW:0] PTR_ONE = 1;

    fetch_entry_t r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         w_full;
    logic         w_push;
    logic         w_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!w_full || w_pop);

    // Storage array; stale contents are harmless because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    // Read/write pointers; flush wins over any same-cycle push or pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch front end: issues sequential word fetches, buffers the
// in-order returns and hands them to decode with PC and PC+4. A redirect
// flushes the buffer and marks every in-flight return for discard.
module ifetch_queue
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pcplus4,
    input  logic        instr_ready
);

    localparam int          CW    = $clog2(DEPTH) + 1;
    localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_ret_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_discard;
    logic          r_mem_req;

    fetch_entry_t  w_head;
    fetch_entry_t  w_entry;
    logic          w_empty;
    logic [CW-1:0] w_occ;
    logic          w_issue;
    logic          w_rvalid;
    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_new_pc;
    logic [CW-1:0] w_out_next;
    logic [CW-1:0] w_occ_next;
    logic [CW:0]   w_load_next;

    assign w_new_pc = redirect_pc & 32'hFFFF_FFFC;
    assign w_issue  = r_mem_req && mem_gnt;
    // An rvalid with nothing outstanding is a protocol error and is ignored.
    assign w_rvalid = mem_rvalid && (r_outstanding != '0);
    // Returns still owed to a flushed stream, or arriving with a redirect, are dropped.
    assign w_push   = w_rvalid && !redirect && (r_discard == '0);
    assign w_pop    = instr_valid && instr_ready && !redirect;
    assign w_entry  = '{pc: r_ret_pc, instr: mem_rdata};

    assign w_out_next  = r_outstanding + CW'(w_issue) - CW'(w_rvalid);
    assign w_occ_next  = redirect ? '0 : (w_occ + CW'(w_push) - CW'(w_pop));
    // Request decision uses next-cycle occupancy so the buffer can never overflow.
    assign w_load_next = {1'b0, w_occ_next} + {1'b0, w_out_next};

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (redirect),
        .i_push  (w_push),
        .i_data  (w_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_count (w_occ)
    );

    // Fetch address, return-PC tracking, in-flight accounting and the registered request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_ret_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_mem_req     <= 1'b0;
        end else begin
            r_outstanding <= w_out_next;
            r_mem_req     <= (w_load_next < LIMIT);
            if (redirect) begin
                r_fetch_pc <= w_new_pc;
                r_ret_pc   <= w_new_pc;
                r_discard  <= w_out_next;
            end else begin
                if (w_issue) r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_push)  r_ret_pc   <= r_ret_pc + 32'd4;
                if (w_rvalid && (r_discard != '0)) r_discard <= r_discard - CW'(1);
            end
        end
    end

    assign mem_req       = r_mem_req;
    assign mem_addr      = r_fetch_pc;
    assign instr_valid   = !w_empty;
    assign instr         = instr_valid ? w_head.instr       : NOP_INSTR;
    assign instr_pc      = instr_valid ? w_head.pc          : 32'h0;
    assign instr_pcplus4 = instr_valid ? w_head.pc + 32'd4  : 32'h0;

    a_rvalid_has_outstanding: assert property (
        @(posedge clk) disable iff (rst) mem_rvalid |-> (r_outstanding != '0));

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;
    import ifetch_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h00400000;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pcplus4;
    logic        instr_ready;

    always #5 clk = ~clk;

    ifetch_queue #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_pcplus4(instr_pcplus4), .instr_ready(instr_ready)
    );

    typedef struct { logic [31:0] addr; int due; int ep; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] ins; logic [31:0] p4; logic [31:0] exp; } obs_t;

    req_t        pend[$];
    obs_t        obs[$];
    int          cyc, epoch, m_occ, m_out, n_issue, n_drop;
    logic [31:0] exp_next;
    int          gnt_pct, rdy_pct, lat_min, lat_max;
    bit          last_rv;
    int          checks, errors;

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h0000_5A13;
    endfunction

    task automatic do_reset(input bit release_rst = 1'b1);
        rst = 1'b1; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        redirect = 0; redirect_pc = 0; instr_ready = 0;
        pend.delete(); obs.delete();
        m_occ = 0; m_out = 0; n_issue = 0; n_drop = 0; exp_next = RPC; epoch++;
        repeat (2) @(negedge clk);
        if (release_rst) rst = 1'b0;
    endtask

    // One cycle: drive inputs at the negedge, record handshakes, advance the reference.
    task automatic tick(input bit redir = 1'b0, input logic [31:0] rpc = 32'h0);
        bit   gnt, rdy, rv, issue, pop, acc;
        req_t r;
        gnt = ($urandom_range(99) < gnt_pct);
        rdy = ($urandom_range(99) < rdy_pct);
        rv  = (pend.size() > 0) && (pend[0].due <= cyc + 1);
        mem_gnt     = gnt;
        mem_rvalid  = rv;
        mem_rdata   = rv ? memword(pend[0].addr) : 32'hDEAD_BEEF;
        instr_ready = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        last_rv     = rv;
        issue = mem_req && gnt;
        pop   = instr_valid && rdy && !redir;
        if (pop) begin
            obs.push_back('{instr_pc, instr, instr_pcplus4, exp_next});
            exp_next = exp_next + 32'd4;
            m_occ--;
        end
        if (rv) begin
            r   = pend.pop_front();
            acc = (r.ep == epoch) && !redir;
            m_out--;
            if (acc) m_occ++; else n_drop++;
        end
        if (issue) begin
            pend.push_back('{mem_addr, cyc + 1 + int'($urandom_range(lat_max, lat_min)), epoch});
            m_out++;
            n_issue++;
        end
        if (redir) begin
            epoch++;
            m_occ = 0;
            exp_next = rpc & 32'hFFFF_FFFC;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        gnt_pct = 0; rdy_pct = 100; lat_min = 1; lat_max = 1;
        do_reset(1'b0);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got=%b want=0", mem_req); end
        checks++; if (mem_addr !== RPC) begin errors++; $display("FAIL rst_mem_addr got=%h want=%h", mem_addr, RPC); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b want=0", instr_valid); end
        checks++; if (instr !== NOP_INSTR) begin errors++; $display("FAIL rst_instr got=%h want=%h", instr, NOP_INSTR); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got=%h want=0", instr_pc); end
        checks++; if (instr_pcplus4 !== 32'h0) begin errors++; $display("FAIL rst_pc4 got=%h want=0", instr_pcplus4); end
        rst = 1'b0;
        tick();
        checks++; if (mem_req !== 1'b1 || mem_addr !== RPC) begin
            errors++; $display("FAIL rst_first_req got req=%b addr=%h want req=1 addr=%h", mem_req, mem_addr, RPC);
        end
    endtask

    task automatic test_stream();
        gnt_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 1;
        do_reset();
        repeat (30) tick();
        // Request rises after edge 1, issue at 2, return at 3, pops from edge 4 through 30.
        checks++; if (obs.size() != 27) begin errors++; $display("FAIL stream_count got=%0d want=27", obs.size()); end
        foreach (obs[i]) begin
            checks++;
            if (obs[i].pc !== RPC + 32'(4 * i) || obs[i].ins !== memword(obs[i].pc) || obs[i].p4 !== obs[i].pc + 32'd4) begin
                errors++;
                $display("FAIL stream[%0d] got pc=%h ins=%h p4=%h want pc=%h ins=%h", i, obs[i].pc, obs[i].ins, obs[i].p4,
                         RPC + 32'(4 * i), memword(RPC + 32'(4 * i)));
            end
        end
    endtask

    task automatic test_full();
        gnt_pct = 100; rdy_pct = 0; lat_min = 1; lat_max = 1;
        do_reset();
        repeat (12) tick();
        checks++; if (n_issue != DEPTH) begin errors++; $display("FAIL full_issues got=%0d want=%0d", n_issue, DEPTH); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL full_req got=%b want=0", mem_req); end
        checks++; if (instr_valid !== 1'b1 || instr_pc !== RPC) begin
            errors++; $display("FAIL full_head got valid=%b pc=%h want valid=1 pc=%h", instr_valid, instr_pc, RPC);
        end
        rdy_pct = 100;
        repeat (12) tick();
        checks++; if (obs.size() != 12) begin errors++; $display("FAIL drain_count got=%0d want=12", obs.size()); end
        foreach (obs[i]) begin
            checks++;
            if (obs[i].pc !== RPC + 32'(4 * i) || obs[i].ins !== memword(obs[i].pc)) begin
                errors++; $display("FAIL drain[%0d] got pc=%h ins=%h want pc=%h", i, obs[i].pc, obs[i].ins, RPC + 32'(4 * i));
            end
        end
    endtask

    task automatic test_redirect_latency();
        gnt_pct = 100; rdy_pct = 100; lat_min = 3; lat_max = 3;
        do_reset();
        for (int i = 0; i < 10 && m_out < 3; i++) tick();
        checks++; if (m_out != 3 || obs.size() != 0) begin
            errors++; $display("FAIL lat_setup got outstanding=%0d pops=%0d want 3 and 0", m_out, obs.size());
        end
        tick(1'b1, 32'h00400040);
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL lat_flush got valid=%b want=0", instr_valid); end
        repeat (20) tick();
        checks++; if (obs.size() < 8 || obs[0].pc !== 32'h00400040) begin
            errors++; $display("FAIL lat_first got n=%0d pc=%h want pc=00400040", obs.size(), obs.size() > 0 ? obs[0].pc : 32'h0);
        end
        foreach (obs[i]) begin
            checks++;
            if (obs[i].pc !== obs[i].exp || obs[i].ins !== memword(obs[i].exp)) begin
                errors++; $display("FAIL lat_stream[%0d] got pc=%h ins=%h want pc=%h ins=%h", i, obs[i].pc, obs[i].ins,
                                   obs[i].exp, memword(obs[i].exp));
            end
        end
    endtask

    task automatic test_redirect_collide();
        int n0;
        gnt_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 1;
        do_reset();
        repeat (8) tick();
        n0 = obs.size();
        tick(1'b1, 32'h00400800);
        checks++; if (last_rv !== 1'b1) begin errors++; $display("FAIL collide_rv got=%b want=1", last_rv); end
        checks++; if (instr_valid !== 1'b0 || instr !== NOP_INSTR || instr_pc !== 32'h0 || instr_pcplus4 !== 32'h0) begin
            errors++; $display("FAIL collide_flush got valid=%b instr=%h pc=%h p4=%h want 0/%h/0/0",
                               instr_valid, instr, instr_pc, instr_pcplus4, NOP_INSTR);
        end
        repeat (10) tick();
        checks++; if (obs.size() <= n0 || obs[n0].pc !== 32'h00400800 || obs[n0].ins !== memword(32'h00400800)) begin
            errors++; $display("FAIL collide_first got n=%0d pc=%h want pc=00400800", obs.size() - n0,
                               obs.size() > n0 ? obs[n0].pc : 32'h0);
        end
        for (int i = n0; i < obs.size(); i++) begin
            checks++;
            if (obs[i].pc !== obs[i].exp || obs[i].ins !== memword(obs[i].exp)) begin
                errors++; $display("FAIL collide_stream[%0d] got pc=%h want pc=%h", i, obs[i].pc, obs[i].exp);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] a0;
        gnt_pct = 0; rdy_pct = 100; lat_min = 1; lat_max = 1;
        do_reset();
        tick();
        a0 = mem_addr;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (mem_req !== 1'b1 || mem_addr !== a0) begin
                errors++; $display("FAIL stall_hold[%0d] got req=%b addr=%h want req=1 addr=%h", i, mem_req, mem_addr, a0);
            end
        end
        tick(1'b1, 32'h00400013);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h00400010) begin
            errors++; $display("FAIL stall_redirect got req=%b addr=%h want req=1 addr=00400010", mem_req, mem_addr);
        end
        gnt_pct = 100;
        repeat (10) tick();
        checks++; if (obs.size() == 0 || obs[0].pc !== 32'h00400010 || obs[0].ins !== memword(32'h00400010)) begin
            errors++; $display("FAIL stall_first got n=%0d pc=%h want pc=00400010", obs.size(), obs.size() > 0 ? obs[0].pc : 32'h0);
        end
    endtask

    task automatic test_reset_mid();
        gnt_pct = 100; rdy_pct = 0; lat_min = 3; lat_max = 3;
        do_reset();
        for (int i = 0; i < 20 && !(m_out == 2 && m_occ + m_out == DEPTH); i++) tick();
        checks++; if (m_out != 2 || instr_valid !== 1'b1) begin
            errors++; $display("FAIL mid_setup got outstanding=%0d valid=%b want 2 and 1", m_out, instr_valid);
        end
        #2 rst = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0 || mem_addr !== RPC || instr_valid !== 1'b0 || instr !== NOP_INSTR ||
                      instr_pc !== 32'h0 || instr_pcplus4 !== 32'h0) begin
            errors++; $display("FAIL mid_reset got req=%b addr=%h valid=%b instr=%h pc=%h p4=%h",
                               mem_req, mem_addr, instr_valid, instr, instr_pc, instr_pcplus4);
        end
        do_reset();
        gnt_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 1;
        repeat (10) tick();
        checks++; if (obs.size() == 0 || obs[0].pc !== RPC || obs[0].ins !== memword(RPC)) begin
            errors++; $display("FAIL mid_restart got n=%0d pc=%h want pc=%h", obs.size(), obs.size() > 0 ? obs[0].pc : 32'h0, RPC);
        end
    endtask

    task automatic test_random();
        logic [31:0] rpc;
        bit          rd;
        gnt_pct = 70; rdy_pct = 60; lat_min = 1; lat_max = 4;
        do_reset();
        tick();
        for (int i = 0; i < 600; i++) begin
            checks++;
            if (mem_req !== ((m_occ + m_out) < DEPTH)) begin
                errors++; $display("FAIL rand_req[%0d] got=%b want=%b (occ=%0d out=%0d)", i, mem_req,
                                   (m_occ + m_out) < DEPTH, m_occ, m_out);
            end
            rd  = ($urandom_range(99) < 4);
            rpc = ($urandom_range(9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
            tick(rd, rpc);
        end
        checks++; if (obs.size() < 50) begin errors++; $display("FAIL rand_count got=%0d want>=50", obs.size()); end
        foreach (obs[i]) begin
            checks++;
            if (obs[i].pc !== obs[i].exp || obs[i].ins !== memword(obs[i].exp) || obs[i].p4 !== obs[i].exp + 32'd4) begin
                errors++; $display("FAIL rand_stream[%0d] got pc=%h ins=%h p4=%h want pc=%h ins=%h", i, obs[i].pc,
                                   obs[i].ins, obs[i].p4, obs[i].exp, memword(obs[i].exp));
            end
        end
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; epoch = 0;
        rst = 1'b1; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        redirect = 0; redirect_pc = 0; instr_ready = 0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_full();
        test_redirect_latency();
        test_redirect_collide();
        test_stall();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
